// File: rtl/u110_ata_cfg.sv
// U110 ATA configuration block: CPU control/status registers, idle-gated PIO mode apply,
// ATA hardware-reset sequencing and drive interrupt latching/masking.
module u110_ata_cfg #(
    parameter int RST_CLKS   = 1000,
    parameter int RECOV_CLKS = 80000
) (
    input  logic       CLK40,
    input  logic       RESETn,
    input  logic       TSn,
    input  logic       RnW,
    input  logic       CFG_ENn,
    input  logic [1:0] A,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       CFG_TACK,
    input  logic       P_BUSY,
    input  logic       S_BUSY,
    input  logic       INTRQ_PRI,
    input  logic       INTRQ_SEC,
    output logic       PPIO,
    output logic       SPIO,
    output logic       ATA_RSTn,
    output logic       ATA_INTn
);

    localparam logic [16:0] RST_LAST = 17'(RST_CLKS - 1);
    localparam logic [16:0] REC_LAST = 17'(RECOV_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        ASSERT    = 2'd2,
        RECOVER   = 2'd3
    } seq_e;

    seq_e        seq_q;
    logic [16:0] cnt_q;
    logic        rstn_q;

    logic        preq_q, sreq_q, pien_q, sien_q;
    logic        preq_d, sreq_d, pien_d, sien_d;
    logic        ppio_q, spio_q, ppio_d, spio_d;
    logic        pirq_q, sirq_q, pirq_d, sirq_d;
    logic [2:0]  psync_q, ssync_q;
    logic        intn_q, tack_q;
    logic [7:0]  dout_q, dout_d;

    logic        acc, rd_acc, wr_ctrl, wr_stat, rst_req;
    logic        p_rise, s_rise, in_seq;
    logic [7:0]  ctrl_rd, stat_rd;
    logic        unused_din;

    assign acc     = !TSn && !CFG_ENn;
    assign rd_acc  = acc && RnW;
    assign wr_ctrl = acc && !RnW && (A == 2'd0);
    assign wr_stat = acc && !RnW && (A == 2'd1);
    assign rst_req = wr_ctrl && D_IN[7];

    assign unused_din = ^D_IN[6:4];

    // [0],[1] are the synchronizer; [2] only delays [1] for rising-edge detection.
    assign p_rise = psync_q[1] && !psync_q[2];
    assign s_rise = ssync_q[1] && !ssync_q[2];
    assign in_seq = (seq_q == ASSERT) || (seq_q == RECOVER);

    assign ctrl_rd = {4'b0, sien_q, pien_q, sreq_q, preq_q};
    assign stat_rd = {seq_q != IDLE, 1'b0, sreq_q != spio_q, preq_q != ppio_q,
                      sirq_q, pirq_q, spio_q, ppio_q};

    always_comb begin
        preq_d = preq_q;
        sreq_d = sreq_q;
        pien_d = pien_q;
        sien_d = sien_q;
        if (wr_ctrl) begin
            preq_d = D_IN[0];
            sreq_d = D_IN[1];
            pien_d = D_IN[2];
            sien_d = D_IN[3];
        end

        // Mode follows the request (including one written this clock) whenever the channel is idle.
        ppio_d = P_BUSY ? ppio_q : preq_d;
        spio_d = S_BUSY ? spio_q : sreq_d;

        // Priority, lowest first: hold, write-1-clear, new edge, reset sequence.
        pirq_d = pirq_q;
        sirq_d = sirq_q;
        if (wr_stat && D_IN[2]) pirq_d = 1'b0;
        if (wr_stat && D_IN[3]) sirq_d = 1'b0;
        if (p_rise)             pirq_d = 1'b1;
        if (s_rise)             sirq_d = 1'b1;
        if (in_seq) begin
            pirq_d = 1'b0;
            sirq_d = 1'b0;
        end

        dout_d = 8'h00;
        if (rd_acc) begin
            case (A)
                2'd0:    dout_d = ctrl_rd;
                2'd1:    dout_d = stat_rd;
                default: dout_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            preq_q  <= 1'b0;
            sreq_q  <= 1'b0;
            pien_q  <= 1'b0;
            sien_q  <= 1'b0;
            ppio_q  <= 1'b0;
            spio_q  <= 1'b0;
            pirq_q  <= 1'b0;
            sirq_q  <= 1'b0;
            psync_q <= 3'b000;
            ssync_q <= 3'b000;
            intn_q  <= 1'b1;
            tack_q  <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            preq_q  <= preq_d;
            sreq_q  <= sreq_d;
            pien_q  <= pien_d;
            sien_q  <= sien_d;
            ppio_q  <= ppio_d;
            spio_q  <= spio_d;
            pirq_q  <= pirq_d;
            sirq_q  <= sirq_d;
            psync_q <= {psync_q[1:0], INTRQ_PRI};
            ssync_q <= {ssync_q[1:0], INTRQ_SEC};
            intn_q  <= !((pirq_q && pien_q) || (sirq_q && sien_q));
            tack_q  <= acc;
            dout_q  <= dout_d;
        end
    end

    // Reset sequencer; a system reset lands directly in ASSERT so the drives always see a full pulse.
    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            seq_q  <= ASSERT;
            cnt_q  <= '0;
            rstn_q <= 1'b0;
        end else begin
            case (seq_q)
                IDLE: begin
                    if (rst_req) seq_q <= WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (!P_BUSY && !S_BUSY) begin
                        seq_q  <= ASSERT;
                        cnt_q  <= '0;
                        rstn_q <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (cnt_q == RST_LAST) begin
                        seq_q  <= RECOVER;
                        cnt_q  <= '0;
                        rstn_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 17'd1;
                    end
                end
                RECOVER: begin
                    if (cnt_q == REC_LAST) begin
                        seq_q <= IDLE;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 17'd1;
                    end
                end
                default: seq_q <= IDLE;
            endcase
        end
    end

    assign D_OUT    = dout_q;
    assign CFG_TACK = tack_q;
    assign PPIO     = ppio_q;
    assign SPIO     = spio_q;
    assign ATA_RSTn = rstn_q;
    assign ATA_INTn = intn_q;

endmodule

// File: tb/tb_u110_ata_cfg.sv
// Scoreboard bench for u110_ata_cfg: randomized register traffic against a behavioural model,
// plus directed reset-sequence, interrupt and mode-apply scenarios.
module tb_u110_ata_cfg;
    localparam int RSTC = 8;
    localparam int RECC = 16;

    logic       CLK40 = 1'b0;
    logic       RESETn = 1'b0;
    logic       TSn = 1'b1, RnW = 1'b1, CFG_ENn = 1'b1;
    logic [1:0] A = 2'd0;
    logic [7:0] D_IN = 8'h00;
    logic [7:0] D_OUT;
    logic       CFG_TACK;
    logic       P_BUSY = 1'b0, S_BUSY = 1'b0;
    logic       INTRQ_PRI = 1'b0, INTRQ_SEC = 1'b0;
    logic       PPIO, SPIO, ATA_RSTn, ATA_INTn;

    u110_ata_cfg #(.RST_CLKS(RSTC), .RECOV_CLKS(RECC)) dut (
        .CLK40(CLK40), .RESETn(RESETn), .TSn(TSn), .RnW(RnW), .CFG_ENn(CFG_ENn),
        .A(A), .D_IN(D_IN), .D_OUT(D_OUT), .CFG_TACK(CFG_TACK),
        .P_BUSY(P_BUSY), .S_BUSY(S_BUSY), .INTRQ_PRI(INTRQ_PRI), .INTRQ_SEC(INTRQ_SEC),
        .PPIO(PPIO), .SPIO(SPIO), .ATA_RSTn(ATA_RSTn), .ATA_INTn(ATA_INTn)
    );

    always #5 CLK40 = ~CLK40;

    typedef struct {
        bit         rd;
        logic [1:0] a;
        logic [7:0] exp;
        int         due;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic neg_rstn;

    // Behavioural model of the CPU-visible state.
    bit m_preq, m_sreq, m_pien, m_sien, m_ppio, m_spio, m_pirq, m_sirq;

    always @(posedge CLK40) cyc <= cyc + 1;

    // Monitor: every acknowledge must match the oldest outstanding access.
    always @(negedge CLK40) begin
        if (CFG_TACK === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL spurious_tack cyc=%0d", cyc);
            end else begin
                e = sbq.pop_front();
                if (cyc != e.due) begin
                    bad++;
                    $display("FAIL tack_latency got_cyc=%0d exp_cyc=%0d", cyc, e.due);
                end
                if (e.rd) begin
                    total++;
                    if (D_OUT !== e.exp) begin
                        bad++;
                        $display("FAIL rd_data A=%0d got=%h exp=%h", e.a, D_OUT, e.exp);
                    end
                end
            end
        end else begin
            total++;
            if (D_OUT !== 8'h00) begin
                bad++;
                $display("FAIL dout_idle got=%h exp=00", D_OUT);
            end
        end
    end

    function automatic logic [7:0] m_stat(input bit seq);
        return {seq, 1'b0, m_sreq ^ m_spio, m_preq ^ m_ppio, m_sirq, m_pirq, m_spio, m_ppio};
    endfunction

    function automatic logic [7:0] m_ctrl();
        return {4'b0, m_sien, m_pien, m_sreq, m_preq};
    endfunction

    task automatic chk1(input string nm, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    // One bus access; ATA_RSTn is sampled mid-cycle as a side effect.
    task automatic acc(input bit rnw, input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp);
        exp_t n;
        n.rd = rnw; n.a = a; n.exp = exp; n.due = cyc + 1;
        sbq.push_back(n);
        TSn = 1'b0; CFG_ENn = 1'b0; RnW = rnw; A = a; D_IN = d;
        @(negedge CLK40);
        neg_rstn = ATA_RSTn;
        @(posedge CLK40); #1;
        TSn = 1'b1; CFG_ENn = 1'b1; RnW = 1'b1; D_IN = 8'h00;
    endtask

    task automatic wr_ctrl(input logic [7:0] d);
        acc(1'b0, 2'd0, d, 8'h00);
        m_preq = d[0]; m_sreq = d[1]; m_pien = d[2]; m_sien = d[3];
        if (!P_BUSY) m_ppio = m_preq;
        if (!S_BUSY) m_spio = m_sreq;
    endtask

    task automatic wr_stat(input logic [7:0] d);
        acc(1'b0, 2'd1, d, 8'h00);
        if (d[2]) m_pirq = 1'b0;
        if (d[3]) m_sirq = 1'b0;
    endtask

    task automatic rd_stat(input bit seq);
        acc(1'b1, 2'd1, 8'h00, m_stat(seq));
    endtask

    task automatic rd_ctrl();
        acc(1'b1, 2'd0, 8'h00, m_ctrl());
    endtask

    task automatic chk_out();
        repeat (2) @(posedge CLK40);
        #1;
        chk1("ppio", PPIO, m_ppio);
        chk1("spio", SPIO, m_spio);
        chk1("intn", ATA_INTn, !((m_pirq && m_pien) || (m_sirq && m_sien)));
        chk1("rstn_idle", ATA_RSTn, 1'b1);
    endtask

    task automatic pulse(input bit sec);
        if (sec) INTRQ_SEC = 1'b1; else INTRQ_PRI = 1'b1;
        repeat (3) @(posedge CLK40);
        #1;
        INTRQ_SEC = 1'b0; INTRQ_PRI = 1'b0;
        repeat (3) @(posedge CLK40);
        #1;
        if (sec) m_sirq = 1'b1; else m_pirq = 1'b1;
    endtask

    // Back-to-back STATUS reads across a reset sequence whose ASSERT phase starts k clocks in.
    task automatic watch(input int k, input int wr_at, input int n);
        logic [7:0] c;
        for (int i = 0; i < n; i++) begin
            if (i == wr_at) begin
                c = m_ctrl();
                c[7] = 1'b1;
                wr_ctrl(c);
            end else begin
                rd_stat(i < k + RSTC + RECC);
            end
            chk1("rst_pulse", neg_rstn, (i < k) || (i >= k + RSTC));
        end
    endtask

    task automatic reset_model();
        m_preq = 0; m_sreq = 0; m_pien = 0; m_sien = 0;
        m_ppio = 0; m_spio = 0; m_pirq = 0; m_sirq = 0;
    endtask

    initial begin
        int op;
        logic [7:0] d;
        reset_model();

        // Power-up
        repeat (2) @(posedge CLK40);
        @(negedge CLK40);
        chk1("rst_ppio", PPIO, 1'b0);
        chk1("rst_spio", SPIO, 1'b0);
        chk1("rst_intn", ATA_INTn, 1'b1);
        chk1("rst_rstn", ATA_RSTn, 1'b0);
        chk1("rst_tack", CFG_TACK, 1'b0);
        repeat (2) @(posedge CLK40);
        #1;
        RESETn = 1'b1;
        watch(0, -1, RSTC + RECC + 3);

        // Mode change deferred while busy
        P_BUSY = 1'b1;
        wr_ctrl(8'h01);
        rd_stat(1'b0);
        chk1("ppio_busy_hold", PPIO, 1'b0);
        P_BUSY = 1'b0;
        @(posedge CLK40); #1;
        m_ppio = m_preq;
        chk1("ppio_on_idle", PPIO, 1'b1);
        rd_stat(1'b0);

        // Interrupt latency, clear, masked secondary
        wr_ctrl(8'h04);
        INTRQ_PRI = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge CLK40); #1;
            if (c == 2) INTRQ_PRI = 1'b0;
            if (c == 3) chk1("intn_lat3", ATA_INTn, 1'b1);
            if (c == 4) chk1("intn_lat4", ATA_INTn, 1'b0);
        end
        m_pirq = 1'b1;
        rd_stat(1'b0);
        wr_stat(8'h04);
        chk_out();
        pulse(1'b1);
        chk_out();
        rd_stat(1'b0);

        // Set edge and write-1-clear on the same clock
        pulse(1'b0);
        INTRQ_PRI = 1'b1;
        repeat (2) begin @(posedge CLK40); #1; end
        wr_stat(8'h04);
        m_pirq = 1'b1;
        INTRQ_PRI = 1'b0;
        repeat (4) begin @(posedge CLK40); #1; end
        rd_stat(1'b0);
        chk_out();

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: wr_ctrl(8'($urandom_range(0, 15)));
                1: rd_stat(1'b0);
                2: rd_ctrl();
                3: begin
                    P_BUSY = !P_BUSY;
                    @(posedge CLK40); #1;
                    if (!P_BUSY) m_ppio = m_preq;
                end
                4: begin
                    S_BUSY = !S_BUSY;
                    @(posedge CLK40); #1;
                    if (!S_BUSY) m_spio = m_sreq;
                end
                5: pulse($urandom_range(0, 1) == 1);
                6: begin
                    d = 8'($urandom);
                    wr_stat(d);
                end
                default: begin
                    acc(1'b0, 2'($urandom_range(2, 3)), 8'($urandom), 8'h00);
                    acc(1'b1, 2'($urandom_range(2, 3)), 8'h00, 8'h00);
                end
            endcase
            chk_out();
        end

        // Quiesce before reset tests
        P_BUSY = 1'b0; S_BUSY = 1'b0;
        @(posedge CLK40); #1;
        m_ppio = m_preq; m_spio = m_sreq;
        wr_ctrl(8'h00);
        wr_stat(8'h0C);
        chk_out();

        // Reset deferred by S_BUSY; a second request during ASSERT is ignored
        S_BUSY = 1'b1;
        wr_ctrl(8'h80);
        for (int i = 0; i < 4; i++) begin
            rd_stat(1'b1);
            chk1("rst_deferred", neg_rstn, 1'b1);
        end
        S_BUSY = 1'b0;
        watch(1, 4, 1 + RSTC + RECC + 3);

        // System reset mid-RECOVER, then a full restart
        wr_ctrl(8'h01);
        wr_ctrl(8'h81);
        watch(1, -1, 1 + RSTC + 4);
        RESETn = 1'b0;
        @(posedge CLK40); #1;
        RESETn = 1'b1;
        reset_model();
        chk1("mid_ppio", PPIO, 1'b0);
        chk1("mid_spio", SPIO, 1'b0);
        chk1("mid_intn", ATA_INTn, 1'b1);
        chk1("mid_rstn", ATA_RSTn, 1'b0);
        chk1("mid_tack", CFG_TACK, 1'b0);
        watch(0, -1, RSTC + RECC + 3);

        // Unused addresses
        acc(1'b1, 2'd2, 8'h00, 8'h00);
        acc(1'b1, 2'd3, 8'h00, 8'h00);

        repeat (4) @(posedge CLK40);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d exp=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/u110_ata_cfg.md
# u110_ata_cfg

ATA configuration and channel-management block for U110. It holds the CPU-visible control/status registers for the primary and secondary ATA channels, and applies per-channel PIO timing-mode changes (PIO2/PIO4) only when that channel's cycle engine is idle. It sequences the ATA hardware-reset pulse and recovery window, and latches and masks drive interrupts into a single interrupt line. It sits beside the ATA cycle engine, feeds that engine's PPIO/SPIO mode inputs, and monitors its busy indications.

## Interface
Parameters:
- RST_CLKS, 1000, CLK40 cycles ATA_RSTn is held low (25 us).
- RECOV_CLKS, 80000, CLK40 cycles of post-reset recovery (2 ms); counter is 17 bits wide.

Ports:
- CLK40  in  1  40 MHz clock.
- RESETn  in  1  reset: synchronous, active-low.
- TSn  in  1  bus transfer start, active-low.
- RnW  in  1  1 = read, 0 = write.
- CFG_ENn  in  1  register window decode, active-low.
- A  in  2  register select.
- D_IN  in  8  write data.
- D_OUT  out  8  read data; valid only while CFG_TACK = 1, otherwise 0.
- CFG_TACK  out  1  one-clock transfer acknowledge.
- P_BUSY, S_BUSY  in  1  primary/secondary ATA cycle in progress.
- INTRQ_PRI, INTRQ_SEC  in  1  asynchronous drive interrupt requests, active-high.
- PPIO, SPIO  out  1  applied timing mode per channel: 1 = PIO4, 0 = PIO2.
- ATA_RSTn  out  1  ATA bus hardware reset, active-low.
- ATA_INTn  out  1  combined interrupt, active-low.

## Operation
- Reset values: PPIO = 0, SPIO = 0, ATA_INTn = 1, CFG_TACK = 0, D_OUT = 0, ATA_RSTn = 0, all enables and pending bits = 0, sequencer = ASSERT with counter = 0.
- Bus access: an access is accepted on a clock where TSn = 0 and CFG_ENn = 0; A, RnW and D_IN are latched on that clock.
  - CFG_TACK is high for exactly the next clock.
  - Register writes take effect on the edge that raises CFG_TACK.
  - Accesses are acknowledged in every sequencer state.
- Register map:
  - A=0 CTRL (R/W): bit0 PPIO request, bit1 SPIO request, bit2 P_IEN, bit3 S_IEN. Bit7 written 1 starts a reset; it is self-clearing and reads 0.
  - A=1 STATUS: bit0 applied PPIO, bit1 applied SPIO, bit2 P_IRQ, bit3 S_IRQ, bit4 P mode change pending, bit5 S mode change pending, bit7 reset sequence active. Writing 1 to bit2/bit3 clears that bit; other written bits are ignored.
  - A=2, A=3: read 0; writes are ignored.
- Mode apply:
  - PPIO takes the value of its request bit on the first clock edge at which P_BUSY = 0; the pending bit is 1 until then.
  - SPIO behaves the same way against S_BUSY.
  - A mode value never changes while its channel's busy input is 1.
- Interrupts:
  - INTRQ_PRI and INTRQ_SEC each pass through a 2-flop synchronizer; a synchronized rising edge sets the matching pending bit.
  - ATA_INTn = !((P_IRQ & P_IEN) | (S_IRQ & S_IEN)), registered.
  - If a set edge and a write-1-clear land on the same clock, the set wins.
- Reset sequencer states: IDLE, WAIT_IDLE, ASSERT, RECOVER.
  - IDLE: a CTRL write with bit7 = 1 moves to WAIT_IDLE.
  - WAIT_IDLE: moves to ASSERT on the first clock where P_BUSY = 0 and S_BUSY = 0.
  - ASSERT: ATA_RSTn = 0 for RST_CLKS clocks, then RECOVER.
  - RECOVER: ATA_RSTn = 1 for RECOV_CLKS clocks, then IDLE.
  - STATUS bit7 = 1 in every state except IDLE.
  - A reset request made while not in IDLE is ignored.
  - In ASSERT and RECOVER, P_IRQ and S_IRQ are held at 0 and interrupt edges are discarded.
- RESETn low at any point, including mid-sequence, forces the reset values. After RESETn is released, a full ASSERT + RECOVER sequence runs.

## Timing
- Access latency: CFG_TACK is high on the clock after the TS clock.
- Back-to-back accesses: a TS accepted on the CFG_TACK clock is acknowledged on the following clock, so one access can complete per clock.
- ATA_RSTn falls on the edge that enters ASSERT, which is the first clock after WAIT_IDLE sees both channels idle. It is low for exactly RST_CLKS clocks.
- After RESETn is released, ATA_RSTn stays low for RST_CLKS clocks counted from the first clock with RESETn = 1.
- STATUS bit7 clears on the first IDLE clock, which is RST_CLKS + RECOVER_CLKS clocks after ASSERT entry.
- Interrupt latency: from an INTRQ rising edge to ATA_INTn = 0 is 3 clocks (2 synchronizer flops + 1 pending register), plus 1 clock for the ATA_INTn register.
- Mode apply latency:
  - Write while the channel is idle: the mode output changes on the CFG_TACK edge.
  - Write while the channel is busy: the mode output changes on the first edge with busy = 0.

## Test plan
- Power-up: hold RESETn low for 4 clocks, release (use RST_CLKS=8, RECOV_CLKS=16 in the bench) -> ATA_RSTn low for 8 clocks, STATUS bit7 = 1 for 24 clocks, PPIO = SPIO = 0, ATA_INTn = 1.
- Mode while busy: hold P_BUSY = 1, write CTRL = 0x01 -> STATUS reads 0x10 and PPIO stays 0. Drop P_BUSY -> PPIO = 1 on that edge and STATUS reads 0x01.
- Interrupt: write CTRL = 0x04, pulse INTRQ_PRI -> ATA_INTn = 0 after 4 clocks and STATUS bit2 = 1. Write STATUS = 0x04 -> ATA_INTn = 1. Pulse INTRQ_SEC with S_IEN = 0 -> S_IRQ = 1 and ATA_INTn stays 1.
- Clear collision: a synchronized INTRQ_PRI edge on the same clock as a write-1-clear of bit2 -> P_IRQ stays 1.
- Reset deferral: write CTRL = 0x80 while S_BUSY = 1 -> ATA_RSTn stays 1 until S_BUSY = 0. A second 0x80 write during ASSERT is ignored and the sequence length is unchanged.
- Mid-sequence reset: assert RESETn for 1 clock during RECOVER -> all outputs return to reset values, then a full 8 + 16 sequence restarts. Reads of A = 2 or 3 return 0x00 with CFG_TACK = 1.
